axi_wr_burst_engine: RTL and testbench
======================================

Name: axi_wr_burst_engine

Overview:
- Write-side consumer of the AXI slave FIFOs. Pops one AW entry, then pops the W entries for that burst.
- Converts each W beat into a single-beat memory write.
- Pushes one B response into the B FIFO.
- Sits between the AW/W FIFO read ports and the B FIFO write port on one side, and the SRAM/peripheral write port on the other.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data beat width (32 or 64)
ID_WIDTH, 4, AXI ID width
LEN_WIDTH, 8, AWLEN width (beats = len+1)

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
aw_rdReq  out  1  pop AW FIFO
aw_rdAck  in  1  AW FIFO non-empty
aw_rdata  in  ID_WIDTH+ADDR_WIDTH+LEN_WIDTH+5  {id,addr,len,size[2:0],burst[1:0]}, MSB first
w_rdReq  out  1  pop W FIFO
w_rdAck  in  1  W FIFO non-empty
w_rdata  in  DATA_WIDTH+DATA_WIDTH/8+1  {data,strb,last}
b_wrReq  out  1  push B FIFO
b_wrAck  in  1  B FIFO not full
b_wdata  out  ID_WIDTH+2  {id,resp}
mem_req  out  1  write request
mem_addr  out  ADDR_WIDTH  beat address
mem_wdata  out  DATA_WIDTH  write data
mem_be  out  DATA_WIDTH/8  byte enables (= WSTRB)
mem_ready  in  1  write accepted this cycle
mem_err  in  1  error for the accepted write, sampled when mem_ready=1

Behaviour:
- Clock and reset: one clock, clk_i. Reset rstn_i is asynchronous and active-low.
- Reset state: all outputs 0, FSM=IDLE, latched fields 0. Reset mid-burst abandons the burst; no B response is issued.
- Pop rule: a FIFO is popped only when rdReq&rdAck are both high in the same cycle. rdata is valid whenever rdAck=1.
- IDLE:
  - aw_rdReq = aw_rdAck.
  - On a pop: latch id, addr, len, size, burst; beat_cnt=0; err_flag=0; go to DATA.
  - First mem_req is asserted 1 cycle after the AW pop at the earliest.
- DATA:
  - mem_req = w_rdAck & ~skip, where skip = illegal size (size > log2(DATA_WIDTH/8)).
  - mem_addr = current address; mem_wdata/mem_be come combinationally from the W head.
  - w_rdReq = w_rdAck & (mem_ready | skip). A beat completes on the W pop.
  - mem_req, once high, holds until mem_ready. Address and data stay stable because the W head is not popped until then.
- On each beat completion:
  - err_flag |= mem_err | skip.
  - If the WLAST bit differs from (beat_cnt==len), set err_flag.
  - beat_cnt++ and advance the address:
    - FIXED (00): unchanged.
    - INCR (01): addr + (1<<size), full ADDR_WIDTH wrap-around.
    - WRAP (10): addr + (1<<size) within the aligned region of (len+1)<<size bytes; the low bits wrap to the region base.
    - RESERVED (11): treated as INCR, err_flag set.
- Burst end: when beat_cnt==len completes, go to RESP. The beat count is governed by len, not by WLAST.
- RESP:
  - b_wrReq=1, b_wdata={id, err_flag?2'b10:2'b00}.
  - When b_wrAck: go to IDLE. The next AW pop is allowed in the following cycle.
  - If the B FIFO is full, stall in RESP.
- Concurrency: only one burst is outstanding. AW is not popped while in DATA or RESP.
- Empty W mid-burst: wait in DATA with mem_req=0.

Optional Feature:
- Macro: AXI_WR_WRAP_CHECK_EN.
- Defined: WRAP bursts with len not in {1,3,7,15} or with an unaligned start address set err_flag at the AW pop. Beats are still written with wrap addressing.
- Undefined: no WRAP legality checks; wrap addressing is applied as-is.

Decomposition:
- Package axi_wr_pkg:
  - burst_e (FIXED/INCR/WRAP/RSVD), resp codes (OKAY=2'b00, SLVERR=2'b10).
  - FSM state enum {IDLE, DATA, RESP}.
  - Packed structs for the aw/w/b FIFO words, with field-offset localparams.
- Sub-module axi_wr_addr_gen: purely combinational next-address computation from (addr,len,size,burst).

Test Plan:
- INCR, addr 0x100, len 3, size 2, mem_ready always 1 -> 4 writes at 0x100, 0x104, 0x108, 0x10C; B={id,00}; W popped 4 times.
- WRAP, addr 0x38, len 3, size 2 -> writes at 0x38, 0x3C, 0x30, 0x34; resp OKAY.
- INCR len 1 with mem_err=1 on beat 0 -> both beats written; resp SLVERR.
- WLAST set on beat 0 of a len=1 burst -> 2 beats consumed; resp SLVERR.
- B FIFO full (b_wrAck=0 for 5 cycles) -> b_wrReq held and b_wdata stable; no AW pop until accept; a queued second AW is popped the cycle after accept.
- rstn_i low during beat 2 of 4 -> outputs 0 immediately; after release FSM=IDLE and no B is pushed.

Source files
------------

// File: rtl/axi_wr_pkg.sv
// Shared types for the AXI write-burst engine: burst/response codes, FSM states,
// FIFO word layouts at the default widths, and bit offsets of the narrow fields.
package axi_wr_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_LEN_W  = 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Low-order field offsets are independent of the width parameters.
  localparam int AW_BURST_LSB = 0;
  localparam int AW_SIZE_LSB  = 2;
  localparam int AW_LEN_LSB   = 5;
  localparam int W_LAST_BIT   = 0;
  localparam int W_STRB_LSB   = 1;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  len;
    logic [2:0]            size;
    burst_e                burst;
  } aw_word_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0]   data;
    logic [AXI_DATA_W/8-1:0] strb;
    logic                    last;
  } w_word_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } b_word_t;

endpackage

// File: rtl/axi_wr_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; RSVD advances like INCR.
module axi_wr_addr_gen
  import axi_wr_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] sum;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    incr      = ADDR_WIDTH'(1) << size;
    sum       = addr + incr;
    // Region of (len+1)<<size bytes; the bits above the mask stay at the region base.
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (sum & wrap_mask);
      default:     next_addr = sum;
    endcase
  end

endmodule

// File: rtl/axi_wr_burst_engine.sv
// Drains one AW entry and its W beats into single-beat memory writes, then pushes one B.
// Optional macro AXI_WR_WRAP_CHECK_EN flags illegal WRAP length/alignment at the AW pop.
module axi_wr_burst_engine
  import axi_wr_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rstn_i,
  output logic                                  aw_rdReq,
  input  logic                                  aw_rdAck,
  input  logic [ID_WIDTH+ADDR_WIDTH+LEN_WIDTH+4:0] aw_rdata,
  output logic                                  w_rdReq,
  input  logic                                  w_rdAck,
  input  logic [DATA_WIDTH+DATA_WIDTH/8:0]      w_rdata,
  output logic                                  b_wrReq,
  input  logic                                  b_wrAck,
  output logic [ID_WIDTH+1:0]                   b_wdata,
  output logic                                  mem_req,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic [DATA_WIDTH-1:0]                 mem_wdata,
  output logic [DATA_WIDTH/8-1:0]               mem_be,
  input  logic                                  mem_ready,
  input  logic                                  mem_err
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int MAX_SIZE = $clog2(STRB_W);
  localparam int AW_ADDR_LSB = AW_LEN_LSB + LEN_WIDTH;
  localparam int AW_ID_LSB   = AW_ADDR_LSB + ADDR_WIDTH;
  localparam int W_DATA_LSB  = W_STRB_LSB + STRB_W;

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_DATA = ST_DATA;
  localparam logic [1:0] S_RESP = ST_RESP;

  logic [1:0]            state_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [LEN_WIDTH-1:0]  beat_cnt_q;
  logic                  err_q;

  logic [ID_WIDTH-1:0]   aw_id;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [LEN_WIDTH-1:0]  aw_len;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic                  w_last;

  logic                  in_data;
  logic                  skip;
  logic                  beat_last;
  logic                  wrap_err;
  logic                  aw_err;
  logic [ADDR_WIDTH-1:0] next_addr;

  assign aw_burst = aw_rdata[AW_BURST_LSB +: 2];
  assign aw_size  = aw_rdata[AW_SIZE_LSB +: 3];
  assign aw_len   = aw_rdata[AW_LEN_LSB +: LEN_WIDTH];
  assign aw_addr  = aw_rdata[AW_ADDR_LSB +: ADDR_WIDTH];
  assign aw_id    = aw_rdata[AW_ID_LSB +: ID_WIDTH];
  assign w_last   = w_rdata[W_LAST_BIT];
  assign w_strb   = w_rdata[W_STRB_LSB +: STRB_W];
  assign w_data   = w_rdata[W_DATA_LSB +: DATA_WIDTH];

`ifdef AXI_WR_WRAP_CHECK_EN
  logic wrap_len_ok;
  logic wrap_align_ok;

  always_comb begin
    wrap_len_ok   = (aw_len == LEN_WIDTH'(1)) || (aw_len == LEN_WIDTH'(3)) ||
                    (aw_len == LEN_WIDTH'(7)) || (aw_len == LEN_WIDTH'(15));
    wrap_align_ok = (aw_addr & ((ADDR_WIDTH'(1) << aw_size) - ADDR_WIDTH'(1))) == '0;
    wrap_err      = (aw_burst == BURST_WRAP) && !(wrap_len_ok && wrap_align_ok);
  end
`else
  assign wrap_err = 1'b0;
`endif

  assign aw_err = (aw_burst == BURST_RSVD) || wrap_err;

  axi_wr_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_addr_gen (
    .addr      (addr_q),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    in_data   = (state_q == S_DATA);
    skip      = (size_q > 3'(MAX_SIZE));
    beat_last = (beat_cnt_q == len_q);
    // Gating with rstn_i keeps the pop request low while reset is held.
    aw_rdReq  = rstn_i && (state_q == S_IDLE) && aw_rdAck;
    mem_req   = in_data && w_rdAck && !skip;
    w_rdReq   = in_data && w_rdAck && (mem_ready || skip);
    mem_addr  = in_data ? addr_q : '0;
    mem_wdata = in_data ? w_data : '0;
    mem_be    = in_data ? w_strb : '0;
    b_wrReq   = (state_q == S_RESP);
    b_wdata   = {id_q, err_q ? RESP_SLVERR : RESP_OKAY};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (aw_rdReq) begin
            id_q       <= aw_id;
            addr_q     <= aw_addr;
            len_q      <= aw_len;
            size_q     <= aw_size;
            burst_q    <= aw_burst;
            beat_cnt_q <= '0;
            err_q      <= aw_err;
            state_q    <= S_DATA;
          end
        end
        S_DATA: begin
          // Beat count follows len; a WLAST disagreement only marks the response.
          if (w_rdReq) begin
            err_q      <= err_q | skip | (mem_ready & mem_err) | (w_last ^ beat_last);
            addr_q     <= next_addr;
            beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
            if (beat_last) state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (b_wrAck) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_burst_engine.sv
// Scoreboard bench: bursts are queued into modelled AW/W FIFOs and their expected
// memory writes and B responses are computed from the burst rules; a monitor compares.
module tb_axi_wr_burst_engine;
  import axi_wr_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int LW = 8;
  localparam int SW = DW / 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] be;
  } mem_exp_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } b_exp_t;

  logic clk_i = 1'b0;
  logic rstn_i;
  logic aw_rdReq, aw_rdAck;
  logic [IW+AW+LW+4:0] aw_rdata;
  logic w_rdReq, w_rdAck;
  logic [DW+SW:0] w_rdata;
  logic b_wrReq, b_wrAck;
  logic [IW+1:0] b_wdata;
  logic mem_req, mem_ready, mem_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_be;

  aw_word_t aw_q[$];
  w_word_t  w_q[$];
  bit       w_err_q[$];
  mem_exp_t mem_exp_q[$];
  b_exp_t   b_exp_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int mem_acc_cnt = 0;
  int b_cnt = 0;
  int w_pop_cnt = 0;
  bit ready_rand = 1'b0;
  bit b_rand = 1'b0;
  bit b_hold = 1'b0;

  axi_wr_burst_engine #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .aw_rdReq  (aw_rdReq),
    .aw_rdAck  (aw_rdAck),
    .aw_rdata  (aw_rdata),
    .w_rdReq   (w_rdReq),
    .w_rdAck   (w_rdAck),
    .w_rdata   (w_rdata),
    .b_wrReq   (b_wrReq),
    .b_wrAck   (b_wrAck),
    .b_wdata   (b_wdata),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ready (mem_ready),
    .mem_err   (mem_err)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected writes and response come straight from the burst rules, beat by beat in closed form.
  task automatic issue_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                             input logic [LW-1:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [15:0] err_mask,
                             input int bad_last);
    aw_word_t aw;
    w_word_t  w;
    mem_exp_t e;
    b_exp_t   b;
    logic [AW-1:0] bytes, region, base, a;
    bit any_err;
    aw.id = id; aw.addr = addr; aw.len = len; aw.size = size; aw.burst = burst_e'(burst);
    aw_q.push_back(aw);
    bytes  = 32'd1 << size;
    region = (32'(len) + 32'd1) << size;
    base   = addr - (addr % region);
    any_err = (burst == 2'b11) || (size > 3'd2) || (bad_last >= 0);
    for (int i = 0; i <= int'(len); i++) begin
      w.data = $urandom;
      w.strb = 4'($urandom_range(0, 15));
      w.last = (i == int'(len)) ^ (i == bad_last);
      w_q.push_back(w);
      w_err_q.push_back(err_mask[i]);
      if (err_mask[i]) any_err = 1'b1;
      case (burst)
        2'b00:   a = addr;
        2'b10:   a = base + ((addr - base + 32'(i) * bytes) % region);
        default: a = addr + 32'(i) * bytes;
      endcase
      if (size <= 3'd2) begin
        e.addr = a; e.data = w.data; e.be = w.strb;
        mem_exp_q.push_back(e);
      end
    end
    b.id = id;
    b.resp = any_err ? 2'b10 : 2'b00;
    b_exp_q.push_back(b);
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(posedge clk_i); #2;
      if (aw_q.size() == 0 && w_q.size() == 0 && mem_exp_q.size() == 0 && b_exp_q.size() == 0)
        done = 1'b1;
    end
    check("drain_before_timeout", done, 1);
  endtask

  // FIFO and memory-side driver: handshakes sampled mid-cycle, applied just after the edge.
  initial begin
    bit aw_p, w_p;
    aw_rdAck = 0; aw_rdata = '0; w_rdAck = 0; w_rdata = '0;
    mem_ready = 1; mem_err = 0; b_wrAck = 1;
    forever begin
      @(negedge clk_i);
      aw_p = aw_rdReq && aw_rdAck;
      w_p  = w_rdReq && w_rdAck;
      @(posedge clk_i); #1;
      if (rstn_i) begin
        if (aw_p) void'(aw_q.pop_front());
        if (w_p) begin
          void'(w_q.pop_front());
          void'(w_err_q.pop_front());
          w_pop_cnt++;
        end
      end
      mem_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      b_wrAck   = b_hold ? 1'b0 : (b_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
      aw_rdAck  = (aw_q.size() != 0);
      aw_rdata  = aw_rdAck ? aw_q[0] : '0;
      w_rdAck   = (w_q.size() != 0);
      w_rdata   = w_rdAck ? w_q[0] : '0;
      mem_err   = w_rdAck ? w_err_q[0] : 1'b0;
    end
  end

  mem_exp_t mon_e;
  b_exp_t   mon_b;

  always @(negedge clk_i) begin
    if (rstn_i === 1'b1) begin
      if (mem_req && mem_ready) begin
        mem_acc_cnt++;
        if (mem_exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL mem_unexpected: write at 0x%0h, none expected", mem_addr);
        end else begin
          mon_e = mem_exp_q.pop_front();
          check("mem_addr", mem_addr, mon_e.addr);
          check("mem_wdata", mem_wdata, mon_e.data);
          check("mem_be", mem_be, mon_e.be);
        end
      end
      if (b_wrReq && b_wrAck) begin
        b_cnt++;
        if (b_exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL b_unexpected: B 0x%0h pushed, none expected", b_wdata);
        end else begin
          mon_b = b_exp_q.pop_front();
          check("b_wdata", b_wdata, {mon_b.id, mon_b.resp});
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, m0, b0;
    bit found;
    logic [1:0] burst;
    logic [2:0] size;
    logic [LW-1:0] len;
    logic [AW-1:0] addr;
    logic [15:0] emask;
    int bad;

    rstn_i = 1'b0;
    // Burst 1 is queued during reset so the AW FIFO looks non-empty while reset is held.
    issue_burst(4'h1, 32'h100, 8'd3, 3'd2, 2'b01, 16'h0, -1);
    repeat (3) @(posedge clk_i);
    #2;
    check("rst_aw_rdReq", aw_rdReq, 0);
    check("rst_w_rdReq", w_rdReq, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_b_wrReq", b_wrReq, 0);
    check("rst_b_wdata", b_wdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata_be", {mem_wdata, mem_be}, 0);
    rstn_i = 1'b1;

    w0 = w_pop_cnt; m0 = mem_acc_cnt;
    wait_idle(200);
    check("incr_w_pops", w_pop_cnt - w0, 4);
    check("incr_mem_writes", mem_acc_cnt - m0, 4);

    w0 = w_pop_cnt;
    issue_burst(4'h2, 32'h38, 8'd3, 3'd2, 2'b10, 16'h0, -1);
    wait_idle(200);
    check("wrap_w_pops", w_pop_cnt - w0, 4);

    m0 = mem_acc_cnt;
    issue_burst(4'h3, 32'h2000, 8'd1, 3'd2, 2'b01, 16'h1, -1);
    wait_idle(200);
    check("memerr_writes", mem_acc_cnt - m0, 2);

    w0 = w_pop_cnt;
    issue_burst(4'h4, 32'h3000, 8'd1, 3'd2, 2'b01, 16'h0, 0);
    wait_idle(200);
    check("early_last_w_pops", w_pop_cnt - w0, 2);

    // B FIFO full for a while, with a second AW already waiting.
    b_hold = 1'b1;
    repeat (2) @(posedge clk_i);
    issue_burst(4'h5, 32'h200, 8'd1, 3'd2, 2'b01, 16'h0, -1);
    issue_burst(4'h6, 32'h300, 8'd0, 3'd2, 2'b00, 16'h0, -1);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk_i);
      if (b_wrReq) found = 1'b1;
    end
    check("bfull_reach_resp", found, 1);
    for (int k = 0; k < 5; k++) begin
      check("bfull_b_wrReq", b_wrReq, 1);
      check("bfull_b_wdata", b_wdata, {4'h5, 2'b00});
      check("bfull_no_aw_pop", aw_rdReq, 0);
      @(negedge clk_i);
    end
    b_hold = 1'b0;
    @(negedge clk_i);
    check("bfull_accept", b_wrReq && b_wrAck, 1);
    @(negedge clk_i);
    check("bfull_next_aw_pop", aw_rdReq, 1);
    wait_idle(200);

    // Reset while beat 2 of 4 is on the memory port.
    b0 = b_cnt; m0 = mem_acc_cnt;
    issue_burst(4'h7, 32'h400, 8'd3, 3'd2, 2'b01, 16'h0, -1);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(posedge clk_i); #2;
      if (mem_acc_cnt - m0 == 2) found = 1'b1;
    end
    check("rst_mid_reach_beat2", found, 1);
    check("rst_mid_pre_req", mem_req, 1);
    check("rst_mid_pre_addr", mem_addr, 32'h408);
    rstn_i = 1'b0;
    #1;
    check("rst_mid_mem_req", mem_req, 0);
    check("rst_mid_w_rdReq", w_rdReq, 0);
    check("rst_mid_mem_addr", mem_addr, 0);
    check("rst_mid_b_wrReq", b_wrReq, 0);
    aw_q.delete(); w_q.delete(); w_err_q.delete(); mem_exp_q.delete(); b_exp_q.delete();
    repeat (3) @(posedge clk_i);
    #2;
    rstn_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #2;
    check("rst_mid_no_b", b_cnt - b0, 0);
    check("rst_mid_writes", mem_acc_cnt - m0, 2);

    ready_rand = 1'b1;
    b_rand = 1'b1;
    for (int g = 0; g < 8; g++) begin
      for (int k = 0; k < 5; k++) begin
        burst = 2'($urandom_range(0, 3));
        size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        if (burst == 2'b10) begin
          case ($urandom_range(0, 3))
            0:       len = 8'd1;
            1:       len = 8'd3;
            2:       len = 8'd7;
            default: len = 8'd15;
          endcase
        end else begin
          len = 8'($urandom_range(0, 15));
        end
        addr  = $urandom;
        emask = ($urandom_range(0, 5) == 0) ? (16'd1 << $urandom_range(0, int'(len))) : 16'h0;
        bad   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(len))) : -1;
        issue_burst(4'($urandom_range(0, 15)), addr, len, size, burst, emask, bad);
      end
      wait_idle(3000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
